// File: rtl/pc_redirect_unit_if.sv
// Fetch-side bus of the PC redirect unit: stall/branch/exception inputs toward fetch,
// the current fetch address and branch statistics back out.
interface pc_redirect_unit_if #(
    parameter int CNT_W = 32
);
    logic             stallF;
    logic             branchD;
    logic             takenD;
    logic [31:0]      targetD;
    logic             flushM;
    logic [31:0]      pc_excM;
    logic [31:0]      pcF;
    logic             inst_en;
    logic             pc_adelF;
    logic             redirect_pend;
    logic [CNT_W-1:0] br_total;
    logic [CNT_W-1:0] br_taken;

    modport master (
        output stallF, branchD, takenD, targetD, flushM, pc_excM,
        input  pcF, inst_en, pc_adelF, redirect_pend, br_total, br_taken
    );

    modport slave (
        input  stallF, branchD, takenD, targetD, flushM, pc_excM,
        output pcF, inst_en, pc_adelF, redirect_pend, br_total, br_taken
    );
endinterface

// File: rtl/pc_redirect_unit.sv
// Fetch PC register and next-PC selector; redirects that arrive while fetch is stalled
// are held until the stall lifts. Also keeps saturating branch performance counters.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int          CNT_W    = 32
) (
    input logic               clk,
    input logic               rst,
    pc_redirect_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PEND_BR  = 2'd1,
        PEND_EXC = 2'd2
    } pend_state_e;

    pend_state_e      state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      pend_tgt_q, pend_tgt_d;
    logic             inst_en_q, inst_en_d;
    logic [CNT_W-1:0] br_total_q, br_total_d;
    logic [CNT_W-1:0] br_taken_q, br_taken_d;

    logic             br_redirect;
    logic             br_count;
    logic             pend_valid;
    logic             pend_accept_br;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        r = (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
        return r;
    endfunction

    assign br_redirect = bus.branchD & bus.takenD;
    assign br_count    = bus.branchD & ~bus.flushM;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            inst_en_q  <= 1'b0;
            br_total_q <= '0;
            br_taken_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_en_q  <= inst_en_d;
            br_total_q <= br_total_d;
            br_taken_q <= br_taken_d;
        end
    end

    // The buffered target is only consulted while the FSM is out of IDLE.
    always_ff @(posedge clk) begin
        pend_tgt_q <= pend_tgt_d;
    end

    always_comb begin
        state_d = state_q;
        if (!bus.stallF) begin
            state_d = IDLE;
        end else if (bus.flushM) begin
            state_d = PEND_EXC;
        end else if (br_redirect && state_q != PEND_EXC) begin
            state_d = PEND_BR;
        end
    end

    always_comb begin
        pend_valid     = (state_q != IDLE);
        pend_accept_br = br_redirect && (state_q != PEND_EXC);
    end

    // A stalled exception always wins the buffer; a stalled branch only takes it if no
    // exception is already waiting there.
    always_comb begin
        pend_tgt_d = pend_tgt_q;
        if (bus.stallF) begin
            if (bus.flushM) begin
                pend_tgt_d = bus.pc_excM;
            end else if (pend_accept_br) begin
                pend_tgt_d = bus.targetD;
            end
        end
    end

    always_comb begin
        pc_d = pc_q;
        if (!bus.stallF) begin
            if (bus.flushM) begin
                pc_d = bus.pc_excM;
            end else if (pend_valid) begin
                pc_d = pend_tgt_q;
            end else if (br_redirect) begin
                pc_d = bus.targetD;
            end else begin
                pc_d = pc_q + 32'd4;
            end
        end
    end

    always_comb begin
        inst_en_d  = 1'b1;
        br_total_d = br_total_q;
        br_taken_d = br_taken_q;
        if (br_count) begin
            br_total_d = sat_inc(br_total_q);
            if (bus.takenD) begin
                br_taken_d = sat_inc(br_taken_q);
            end
        end
    end

    assign bus.pcF           = pc_q;
    assign bus.inst_en       = inst_en_q;
    assign bus.pc_adelF      = |pc_q[1:0];
    assign bus.redirect_pend = pend_valid;
    assign bus.br_total      = br_total_q;
    assign bus.br_taken      = br_taken_q;

endmodule
